// File: rtl/dpe_demultiplexer_if.sv
// AXI-Stream bundle shared by the DPE multiplexer/demultiplexer stages.
// Provides a master (m_axis) and a slave (s_axis) view of one stream.
interface dpe_if #(
  parameter int TDATA_WIDTH = 128,
  parameter int TUSER_WIDTH = 5
);
  localparam int TKEEP_WIDTH = (TDATA_WIDTH + 7) / 8;

  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic [TKEEP_WIDTH-1:0] tkeep;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport m_axis (
    output tvalid, tdata, tkeep, tlast, tuser,
    input  tready
  );

  modport s_axis (
    input  tvalid, tdata, tkeep, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/dpe_demultiplexer.sv
// Steers whole packets from one merged AXI-Stream to five egress streams,
// selected by a one-hot tuser on the head beat; illegal heads are dropped.
module dpe_demultiplexer #(
  parameter int TDATA_WIDTH = 128,
  parameter int TUSER_WIDTH = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  output logic        is_idle,
  output logic [15:0] drop_cnt,
  dpe_if.s_axis       inp,
  dpe_if.m_axis       outp0,
  dpe_if.m_axis       outp1,
  dpe_if.m_axis       outp2,
  dpe_if.m_axis       outp3,
  dpe_if.m_axis       outp4
);

  localparam int NPORT  = 5;
  localparam int KEEP_W = (TDATA_WIDTH + 7) / 8;
  localparam int BEAT_W = TDATA_WIDTH + KEEP_W + 1 + TUSER_WIDTH;

  typedef enum logic [1:0] {IDLE, HEAD, FWD, DROP} state_t;

  function automatic logic is_onehot(input logic [TUSER_WIDTH-1:0] u);
    return (u != '0) && ((u & (u - 1'b1)) == '0);
  endfunction

  function automatic logic [2:0] oh_to_idx(input logic [TUSER_WIDTH-1:0] u);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (u[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [TUSER_WIDTH-1:0] idx_to_oh(input logic [2:0] idx);
    return TUSER_WIDTH'(1) << idx;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  state_t                 state;
  logic [2:0]             sel;
  logic                   legal;
  logic [2:0]             head_idx;
  logic [2:0]             tgt;
  logic                   route_vld;
  logic                   in_rdy;
  logic                   hs;
  logic [TUSER_WIDTH-1:0] route_oh;
  logic [BEAT_W-1:0]      beat_p0;
  logic [NPORT-1:0]       s_vld;
  logic [NPORT-1:0]       s_rdy;
  logic [NPORT-1:0]       m_rdy;
  logic [NPORT-1:0]       egr_vld;
  logic [BEAT_W-1:0]      egr_beat [NPORT];

  // Stage p0: ingress decode and routing toward the selected egress
  always_comb begin
    legal     = is_onehot(inp.tuser);
    head_idx  = oh_to_idx(inp.tuser);
    tgt       = sel;
    route_oh  = idx_to_oh(sel);
    route_vld = 1'b0;
    in_rdy    = 1'b0;
    case (state)
      HEAD: begin
        tgt       = head_idx;
        route_oh  = inp.tuser;
        route_vld = inp.tvalid & legal;
        if (inp.tvalid) in_rdy = legal ? s_rdy[head_idx] : 1'b1;
      end
      FWD: begin
        route_vld = inp.tvalid;
        in_rdy    = s_rdy[sel];
      end
      DROP:    in_rdy = 1'b1;
      default: in_rdy = 1'b0;
    endcase
    if (rst) begin
      in_rdy    = 1'b0;
      route_vld = 1'b0;
    end
  end

  assign inp.tready = in_rdy;
  assign hs         = inp.tvalid & in_rdy;
  assign beat_p0    = {inp.tdata, inp.tkeep, inp.tlast, route_oh};
  assign s_vld      = route_vld ? NPORT'(idx_to_oh(tgt)) : '0;
  assign is_idle    = (state == IDLE) && (egr_vld == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (!pause) state <= HEAD;
        HEAD: begin
          if (!inp.tvalid) begin
            if (pause) state <= IDLE;
          end else if (legal) begin
            if (hs) begin
              sel   <= head_idx;
              state <= !inp.tlast ? FWD : (pause ? IDLE : HEAD);
            end
          end else if (inp.tlast) begin
            drop_cnt <= sat_inc(drop_cnt);
            state    <= pause ? IDLE : HEAD;
          end else begin
            state <= DROP;
          end
        end
        FWD: if (hs && inp.tlast) state <= pause ? IDLE : HEAD;
        DROP: begin
          if (hs && inp.tlast) begin
            drop_cnt <= sat_inc(drop_cnt);
            state    <= pause ? IDLE : HEAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p1: per-egress two-entry skid register (main + skid slot)
  for (genvar k = 0; k < NPORT; k++) begin : g_egress
    logic              vld_p1;
    logic              skd_vld_p1;
    logic [BEAT_W-1:0] beat_p1;
    logic [BEAT_W-1:0] skd_p1;
    logic              m_xfer;
    logic              s_xfer;

    assign s_rdy[k] = ~skd_vld_p1;
    assign m_xfer   = vld_p1 & m_rdy[k];
    assign s_xfer   = s_vld[k] & s_rdy[k];

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1     <= 1'b0;
        skd_vld_p1 <= 1'b0;
      end else if (skd_vld_p1) begin
        if (m_xfer) skd_vld_p1 <= 1'b0;
      end else if (s_xfer) begin
        if (vld_p1 && !m_xfer) skd_vld_p1 <= 1'b1;
        else                   vld_p1     <= 1'b1;
      end else if (m_xfer) begin
        vld_p1 <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (skd_vld_p1) begin
        if (m_xfer) beat_p1 <= skd_p1;
      end else if (s_xfer) begin
        if (vld_p1 && !m_xfer) skd_p1  <= beat_p0;
        else                   beat_p1 <= beat_p0;
      end
    end

    assign egr_vld[k]  = vld_p1;
    assign egr_beat[k] = beat_p1;
  end

  assign outp0.tvalid = egr_vld[0];
  assign outp1.tvalid = egr_vld[1];
  assign outp2.tvalid = egr_vld[2];
  assign outp3.tvalid = egr_vld[3];
  assign outp4.tvalid = egr_vld[4];

  assign {outp0.tdata, outp0.tkeep, outp0.tlast, outp0.tuser} = egr_beat[0];
  assign {outp1.tdata, outp1.tkeep, outp1.tlast, outp1.tuser} = egr_beat[1];
  assign {outp2.tdata, outp2.tkeep, outp2.tlast, outp2.tuser} = egr_beat[2];
  assign {outp3.tdata, outp3.tkeep, outp3.tlast, outp3.tuser} = egr_beat[3];
  assign {outp4.tdata, outp4.tkeep, outp4.tlast, outp4.tuser} = egr_beat[4];

  assign m_rdy = {outp4.tready, outp3.tready, outp2.tready, outp1.tready, outp0.tready};

endmodule

// File: tb/tb_dpe_demultiplexer.sv
// Directed bench for dpe_demultiplexer: expected egress beats are queued at
// issue time and a free-running monitor pops and compares them on delivery.
module tb_dpe_demultiplexer;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 5;
  localparam int BW = DW + KW + 1 + UW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pause = 1'b0;
  logic        is_idle;
  logic [15:0] drop_cnt;
  logic [4:0]  rdy = 5'b11111;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [BW-1:0] q [5][$];
  logic [4:0]    mv;
  logic [BW-1:0] mb [5];

  dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) inp_if ();
  dpe_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) outp_if [5] ();

  dpe_demultiplexer #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pause    (pause),
    .is_idle  (is_idle),
    .drop_cnt (drop_cnt),
    .inp      (inp_if),
    .outp0    (outp_if[0]),
    .outp1    (outp_if[1]),
    .outp2    (outp_if[2]),
    .outp3    (outp_if[3]),
    .outp4    (outp_if[4])
  );

  for (genvar k = 0; k < 5; k++) begin : g_port
    assign mv[k] = outp_if[k].tvalid;
    assign mb[k] = {outp_if[k].tdata, outp_if[k].tkeep, outp_if[k].tlast, outp_if[k].tuser};
    assign outp_if[k].tready = rdy[k];
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until accepted; port<0 means no egress expected.
  task automatic send(input logic [DW-1:0] d, input logic last, input logic [UW-1:0] u,
                      input int port);
    int n;
    logic [KW-1:0] kp;
    logic [UW-1:0] eu;
    n  = 0;
    kp = d[KW-1:0] ^ 16'hFFFF;
    inp_if.tvalid = 1'b1;
    inp_if.tdata  = d;
    inp_if.tkeep  = kp;
    inp_if.tlast  = last;
    inp_if.tuser  = u;
    @(negedge clk);
    while (!inp_if.tready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!inp_if.tready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: tready got=0 expected=1 data=%h", d);
    end else if (port >= 0) begin
      eu = 5'b00001 << port;
      q[port].push_back({d, kp, last, eu});
    end
    @(posedge clk);
    #1;
    inp_if.tvalid = 1'b0;
  endtask

  // Monitor: every delivered egress beat must match the head of its queue.
  initial begin
    logic [BW-1:0] exp;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        if (mv[k] && rdy[k]) begin
          total++;
          if (q[k].size() == 0) begin
            bad++;
            $display("FAIL egress%0d_unexpected: got=%h expected=none", k, mb[k]);
          end else begin
            exp = q[k].pop_front();
            if (mb[k] !== exp) begin
              bad++;
              $display("FAIL egress%0d_beat: got=%h expected=%h", k, mb[k], exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int c0;
    int n;
    inp_if.tvalid = 1'b0;
    inp_if.tdata  = '0;
    inp_if.tkeep  = '0;
    inp_if.tlast  = 1'b0;
    inp_if.tuser  = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_is_idle", 32'(is_idle), 32'd1);
    chk("reset_tready", 32'(inp_if.tready), 32'd0);
    chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("reset_tvalid", 32'(mv), 32'd0);
    @(posedge clk);
    #1;

    // 1-beat packet to outp2
    send(128'hA5, 1'b1, 5'b00100, 2);
    repeat (2) @(posedge clk);
    #1;
    chk("t1_drop_cnt", 32'(drop_cnt), 32'd0);

    // 3-beat packet to outp4; later beats carry stray tuser
    send(128'h1111, 1'b0, 5'b10000, 4);
    send(128'h2222, 1'b0, 5'b00001, 4);
    send(128'h3333, 1'b1, 5'b00001, 4);

    // 6-beat packet to outp1 under backpressure
    rdy[1] = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(128'hB000 + 128'(i), (i == 5), (i == 0) ? 5'b00010 : 5'b01000, 1);
      end
      begin
        repeat (4) @(negedge clk);
        chk("t3_tready_stalled", 32'(inp_if.tready), 32'd0);
        chk("t3_outp1_held", 32'(mv[1]), 32'd1);
        repeat (2) @(posedge clk);
        #1 rdy[1] = 1'b1;
      end
    join

    // Multi-hot then zero-tuser packets are dropped at full rate
    c0 = cyc;
    send(128'hC0, 1'b0, 5'b00011, -1);
    send(128'hC1, 1'b0, 5'b00000, -1);
    send(128'hC2, 1'b0, 5'b11111, -1);
    send(128'hC3, 1'b1, 5'b00000, -1);
    send(128'hC4, 1'b1, 5'b00000, -1);
    chk("t4_drop_cycles", 32'(cyc - c0), 32'd5);
    @(negedge clk);
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd2);
    @(posedge clk);
    #1;

    // pause raised mid-packet: the packet completes, then ingress halts
    send(128'hD0, 1'b0, 5'b01000, 3);
    pause = 1'b1;
    send(128'hD1, 1'b0, 5'b00000, 3);
    send(128'hD2, 1'b0, 5'b00000, 3);
    send(128'hD3, 1'b1, 5'b00000, 3);
    fork
      send(128'hE0, 1'b1, 5'b00001, 0);
      begin
        @(negedge clk);
        chk("t5_not_idle_draining", 32'(is_idle), 32'd0);
        chk("t5_tready_paused", 32'(inp_if.tready), 32'd0);
        n = 0;
        while (!is_idle && n < 20) begin
          n++;
          @(negedge clk);
        end
        chk("t5_is_idle", 32'(is_idle), 32'd1);
        repeat (2) @(negedge clk);
        chk("t5_tready_still_paused", 32'(inp_if.tready), 32'd0);
        @(posedge clk);
        #1 pause = 1'b0;
      end
    join

    // Saturate the drop counter with back-to-back 1-beat illegal packets
    inp_if.tvalid = 1'b1;
    inp_if.tdata  = 128'hF;
    inp_if.tkeep  = '1;
    inp_if.tlast  = 1'b1;
    inp_if.tuser  = 5'b00000;
    @(negedge clk);
    chk("t6_drop_tready", 32'(inp_if.tready), 32'd1);
    repeat (65532) @(posedge clk);
    #1 inp_if.tvalid = 1'b0;
    @(negedge clk);
    chk("t6_drop_cnt_fffe", 32'(drop_cnt), 32'h0000FFFE);
    @(posedge clk);
    #1;
    send(128'hF1, 1'b1, 5'b00000, -1);
    @(negedge clk);
    chk("t6_drop_cnt_ffff", 32'(drop_cnt), 32'h0000FFFF);
    @(posedge clk);
    #1;
    send(128'hF2, 1'b1, 5'b10100, -1);
    @(negedge clk);
    chk("t6_drop_cnt_sat", 32'(drop_cnt), 32'h0000FFFF);
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled packet to outp2
    rdy[2] = 1'b0;
    send(128'h9990, 1'b0, 5'b00100, -1);
    send(128'h9991, 1'b0, 5'b00000, -1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_tvalid", 32'(mv), 32'd0);
    chk("t6_rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t6_rst_is_idle", 32'(is_idle), 32'd1);
    @(posedge clk);
    #1 rdy[2] = 1'b1;
    send(128'h7777, 1'b1, 5'b00010, 1);

    repeat (5) @(negedge clk);
    for (int k = 0; k < 5; k++)
      chk($sformatf("queue%0d_empty", k), 32'(q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
